// File: rtl/mux_display_scan.sv
// Time-multiplexed display scanner: steps through P_CH channels every P_DIV cycles
// (or holds a manually selected channel) and drives the registered segment data and anode enables.
module mux_display_scan #(
  parameter int unsigned P_WIDTH = 7,
  parameter int unsigned P_CH    = 4,
  parameter int unsigned P_DIV   = 50000,
  localparam int unsigned W_IDX  = (P_CH > 1) ? $clog2(P_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     modo,
  input  logic [W_IDX-1:0]         sel_man,
  input  logic [P_CH*P_WIDTH-1:0]  ent,
  input  logic [P_CH-1:0]          blank,
  output logic [P_WIDTH-1:0]       out,
  output logic [P_CH-1:0]          an,
  output logic [W_IDX-1:0]         idx,
  output logic                     tick
);

  localparam int unsigned W_CNT = (P_DIV > 1) ? $clog2(P_DIV) : 1;

  localparam logic [W_CNT-1:0] CNT_MAX = W_CNT'(P_DIV - 1);
  localparam logic [W_IDX-1:0] IDX_MAX = W_IDX'(P_CH - 1);
  localparam logic [W_IDX:0]   NUM_CH  = (W_IDX + 1)'(P_CH);

  logic [W_CNT-1:0]   cnt_q, cnt_d;
  logic [W_IDX-1:0]   idx_q, idx_d;
  logic [P_WIDTH-1:0] out_q, out_d;
  logic [P_CH-1:0]    an_q, an_d;
  logic               tick_q, tick_d;

  logic [P_WIDTH-1:0] act_data;
  logic               act_blank;
  logic [P_CH-1:0]    act_hot;

  // Prescaler and channel index; manual mode parks the prescaler at zero.
  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    tick_d = 1'b0;
    if (modo) begin
      cnt_d = '0;
      idx_d = ({1'b0, sel_man} >= NUM_CH) ? IDX_MAX : sel_man;
    end else if (en) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d  = '0;
        idx_d  = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Output stage samples the index held before the edge, giving a fixed one-cycle lag.
  always_comb begin
    act_data  = '0;
    act_blank = 1'b0;
    act_hot   = '0;
    for (int unsigned k = 0; k < P_CH; k++) begin
      if (idx_q == W_IDX'(k)) begin
        act_data   = ent[k*P_WIDTH +: P_WIDTH];
        act_blank  = blank[k];
        act_hot[k] = 1'b1;
      end
    end
    out_d = act_blank ? '0 : act_data;
    an_d  = act_blank ? '0 : act_hot;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      out_q  <= '0;
      an_q   <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      out_q  <= out_d;
      an_q   <= an_d;
      tick_q <= tick_d;
    end
  end

  assign out  = out_q;
  assign an   = an_q;
  assign idx  = idx_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_mux_display_scan.sv
// Bench for mux_display_scan: fixed vector table, directed corner sequences and a
// randomized run compared against a dwell-arithmetic reference model.
module tb_mux_display_scan;

  localparam int P_WIDTH = 7;
  localparam int P_CH    = 4;
  localparam int P_DIV   = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        modo = 1'b0;
  logic [1:0]  sel_man = '0;
  logic [27:0] ent;
  logic [3:0]  blank = '0;

  logic [6:0]  out;
  logic [3:0]  an;
  logic [1:0]  idx;
  logic        tick;

  logic [6:0]  out3;
  logic [2:0]  an3;
  logic [1:0]  idx3;
  logic        tick3;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the active channel is base + (enabled cycles since resume) / P_DIV.
  int m_base = 0;
  int m_en   = 0;
  int e_idx, e_out, e_an, e_tick;

  always #5 clk = ~clk;

  mux_display_scan #(.P_WIDTH(P_WIDTH), .P_CH(P_CH), .P_DIV(P_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .modo(modo), .sel_man(sel_man),
    .ent(ent), .blank(blank), .out(out), .an(an), .idx(idx), .tick(tick)
  );

  mux_display_scan #(.P_WIDTH(P_WIDTH), .P_CH(3), .P_DIV(P_DIV)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .modo(modo), .sel_man(sel_man),
    .ent(ent[20:0]), .blank(blank[2:0]), .out(out3), .an(an3), .idx(idx3), .tick(tick3)
  );

  typedef struct {
    bit rst_n;
    bit en;
    bit modo;
    int idx;
    int out;
    int an;
    int tick;
  } vec_t;

  vec_t tbl[15];

  function automatic int cur_idx();
    return (m_base + m_en / P_DIV) % P_CH;
  endfunction

  task automatic model_edge();
    int c;
    c = cur_idx();
    if (!rst_n) begin
      m_base = 0; m_en = 0;
      e_out = 0; e_an = 0; e_tick = 0;
    end else begin
      if (blank[c]) begin
        e_out = 0; e_an = 0;
      end else begin
        e_out = int'(ent[c*P_WIDTH +: P_WIDTH]);
        e_an  = 1 << c;
      end
      if (modo) begin
        m_base = (int'(sel_man) >= P_CH) ? P_CH - 1 : int'(sel_man);
        m_en   = 0;
        e_tick = 0;
      end else if (en) begin
        m_en   = m_en + 1;
        e_tick = (m_en % P_DIV == 0) ? 1 : 0;
      end else begin
        e_tick = 0;
      end
    end
    e_idx = cur_idx();
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit use_model);
    model_edge();
    @(posedge clk);
    #1;
    if (use_model) begin
      check("model_idx", int'(idx), e_idx);
      check("model_out", int'(out), e_out);
      check("model_an", int'(an), e_an);
      check("model_tick", int'(tick), e_tick);
    end
  endtask

  task automatic seek(input int want_idx, input string name);
    for (int i = 0; i < 40 && !(cur_idx() == want_idx && m_en % P_DIV == 1); i++) step(1);
    check(name, int'(idx), want_idx);
  endtask

  initial begin
    ent = {7'h4F, 7'h5B, 7'h06, 7'h3F};

    tbl[0]  = '{0, 0, 0, 0, 'h00, 'h0, 0};
    tbl[1]  = '{0, 0, 0, 0, 'h00, 'h0, 0};
    tbl[2]  = '{1, 1, 0, 0, 'h3F, 'h1, 0};
    tbl[3]  = '{1, 1, 0, 0, 'h3F, 'h1, 0};
    tbl[4]  = '{1, 1, 0, 1, 'h3F, 'h1, 1};
    tbl[5]  = '{1, 1, 0, 1, 'h06, 'h2, 0};
    tbl[6]  = '{1, 1, 0, 1, 'h06, 'h2, 0};
    tbl[7]  = '{1, 1, 0, 2, 'h06, 'h2, 1};
    tbl[8]  = '{1, 1, 0, 2, 'h5B, 'h4, 0};
    tbl[9]  = '{1, 1, 0, 2, 'h5B, 'h4, 0};
    tbl[10] = '{1, 1, 0, 3, 'h5B, 'h4, 1};
    tbl[11] = '{1, 1, 0, 3, 'h4F, 'h8, 0};
    tbl[12] = '{1, 1, 0, 3, 'h4F, 'h8, 0};
    tbl[13] = '{1, 1, 0, 0, 'h4F, 'h8, 1};
    tbl[14] = '{1, 1, 0, 0, 'h3F, 'h1, 0};

    // Reset then automatic scan against fixed expectations.
    for (int i = 0; i < 15; i++) begin
      rst_n = tbl[i].rst_n; en = tbl[i].en; modo = tbl[i].modo;
      step(0);
      check($sformatf("tbl%0d_idx", i), int'(idx), tbl[i].idx);
      check($sformatf("tbl%0d_out", i), int'(out), tbl[i].out);
      check($sformatf("tbl%0d_an", i), int'(an), tbl[i].an);
      check($sformatf("tbl%0d_tick", i), int'(tick), tbl[i].tick);
    end

    // Enable dropped mid-dwell on channel 2, then resumed with the remaining count.
    seek(2, "hold_seek_idx");
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("hold_idx", int'(idx), 2);
      check("hold_out", int'(out), 'h5B);
      check("hold_tick", int'(tick), 0);
    end
    en = 1'b1;
    step(1);
    check("resume_idx_mid", int'(idx), 2);
    step(1);
    check("resume_idx", int'(idx), 3);
    check("resume_tick", int'(tick), 1);

    // Manual selection, including the clamp on a 3-channel build.
    modo = 1'b1; sel_man = 2'd3;
    step(1);
    check("man_idx3", int'(idx), 3);
    check("man_tick", int'(tick), 0);
    check("clamp_idx", int'(idx3), 2);
    step(1);
    check("man_out3", int'(out), 'h4F);
    check("man_an3", int'(an), 'h8);
    check("clamp_an", int'(an3), 'h4);
    check("clamp_out", int'(out3), 'h5B);
    sel_man = 2'd1;
    step(1);
    check("man_idx1", int'(idx), 1);
    step(1);
    check("man_out1", int'(out), 'h06);
    check("man_an1", int'(an), 'h2);
    check("man_tick1", int'(tick), 0);

    // Resume auto from the held channel, then blank channel 2.
    modo = 1'b0; en = 1'b1; blank = 4'b0100;
    for (int i = 0; i < 15; i++) begin
      int c;
      c = cur_idx();
      step(1);
      if (c == 2) begin
        check("blank_out", int'(out), 0);
        check("blank_an", int'(an), 0);
      end
    end
    blank = '0;

    // Reset pulse while on channel 3 in manual mode.
    seek(3, "rst_seek_idx");
    modo = 1'b1; sel_man = 2'd3; rst_n = 1'b0;
    step(1);
    check("rst_idx", int'(idx), 0);
    check("rst_out", int'(out), 0);
    check("rst_an", int'(an), 0);
    check("rst_tick", int'(tick), 0);
    rst_n = 1'b1; modo = 1'b0;
    step(1);
    check("post_rst_out", int'(out), 'h3F);
    check("post_rst_an", int'(an), 'h1);
    for (int i = 0; i < 4; i++) step(1);

    // Randomized run against the model.
    for (int i = 0; i < 400; i++) begin
      rst_n   = ($urandom_range(0, 49) != 0);
      en      = ($urandom_range(0, 3) != 0);
      modo    = ($urandom_range(0, 9) == 0);
      sel_man = 2'($urandom);
      if ($urandom_range(0, 19) == 0) blank = 4'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        int k;
        k = $urandom_range(0, 3);
        ent[k*P_WIDTH +: P_WIDTH] = 7'($urandom);
      end
      step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
